pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 92 +++++++++
 tb/tb_pc_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with stall, branch/eret redirect, exception entry and a
// one-deep pending-redirect register that carries a redirect across a stall.
module pc_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
   parameter int unsigned      STEP      = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc_in,
   input  logic             exc_req,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             pend,
   output logic             misalign,
   output logic [WIDTH-1:0] badaddr
);

   localparam int unsigned ALIGN_BITS = $clog2(STEP);

   typedef enum logic {RUN, HOLD} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] pend_tgt, next_pend_tgt;
   logic [WIDTH-1:0] next_pc, next_badaddr;
   logic             next_misalign;
   logic             redirect;
   logic             target_misaligned;
   logic [WIDTH-1:0] target;

   assign pc_seq            = pc + WIDTH'(STEP);
   assign pend              = (state == HOLD);
   assign redirect          = eret_req | br_valid;
   assign target            = eret_req ? epc_in : br_target;
   assign target_misaligned = redirect && (target[ALIGN_BITS-1:0] != '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= RUN;
         pc       <= RESET_VEC;
         pend_tgt <= '0;
         badaddr  <= '0;
         misalign <= 1'b0;
      end else begin
         state    <= next_state;
         pc       <= next_pc;
         pend_tgt <= next_pend_tgt;
         badaddr  <= next_badaddr;
         misalign <= next_misalign;
      end
   end

   // Exceptions and misaligned redirects ignore stall; aligned redirects
   // arriving during a stall are parked in pend_tgt until the stall lifts.
   always_comb begin
      next_state    = state;
      next_pc       = pc;
      next_pend_tgt = pend_tgt;
      next_badaddr  = badaddr;
      next_misalign = 1'b0;
      if (exc_req) begin
         next_pc    = EXC_VEC;
         next_state = RUN;
      end else if (target_misaligned) begin
         next_pc       = EXC_VEC;
         next_badaddr  = target;
         next_misalign = 1'b1;
         next_state    = RUN;
      end else if (redirect) begin
         if (stall) begin
            next_pend_tgt = target;
            next_state    = HOLD;
         end else begin
            next_pc    = target;
            next_state = RUN;
         end
      end else if (state == HOLD) begin
         if (!stall) begin
            next_pc    = pend_tgt;
            next_state = RUN;
         end
      end else if (!stall) begin
         next_pc = pc_seq;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a default 32-bit instance and an 8-bit
// instance used for wrap-around and mid-HOLD asynchronous reset.
module tb_pc_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr_n = 1'b1, stall = 1'b0, br_valid = 1'b0, eret_req = 1'b0, exc_req = 1'b0;
   logic [31:0] br_target = '0, epc_in = '0;
   logic [31:0] pc, pc_seq, badaddr;
   logic        pend, misalign;

   logic        clr8 = 1'b1, stall8 = 1'b0, br_valid8 = 1'b0, eret8 = 1'b0, exc8 = 1'b0;
   logic [7:0]  br_target8 = '0, epc8 = '0;
   logic [7:0]  pc8, pc_seq8, badaddr8;
   logic        pend8, misalign8;

   int nvec  = 0;
   int nfail = 0;

   pc_unit dut (
      .clk(clk), .clr_n(clr_n), .stall(stall), .br_valid(br_valid),
      .br_target(br_target), .eret_req(eret_req), .epc_in(epc_in),
      .exc_req(exc_req), .pc(pc), .pc_seq(pc_seq), .pend(pend),
      .misalign(misalign), .badaddr(badaddr)
   );

   pc_unit #(.WIDTH(8), .RESET_VEC(8'hF8)) dut8 (
      .clk(clk), .clr_n(clr8), .stall(stall8), .br_valid(br_valid8),
      .br_target(br_target8), .eret_req(eret8), .epc_in(epc8),
      .exc_req(exc8), .pc(pc8), .pc_seq(pc_seq8), .pend(pend8),
      .misalign(misalign8), .badaddr(badaddr8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #1 clr_n = 1'b0; clr8 = 1'b0;
      #2;
      check("rst_pc", pc, 32'h3000);
      check("rst_pend", {31'b0, pend}, 32'h0);
      check("rst_mis", {31'b0, misalign}, 32'h0);
      check("rst_bad", badaddr, 32'h0);
      check("rst_pc8", {24'b0, pc8}, 32'hF8);

      // sequential fetch after release
      @(negedge clk);
      clr_n = 1'b1;
      #1 check("seq0", pc, 32'h3000);
      tick(); check("seq1", pc, 32'h3004);
      tick(); check("seq2", pc, 32'h3008);
      tick(); check("seq3", pc, 32'h300C);
      check("pc_seq", pc_seq, 32'h3010);

      // branch during stall, held two more cycles
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
      tick(); check("stall_br_pc", pc, 32'h300C); check("stall_br_pend", {31'b0, pend}, 32'h1);
      br_valid = 1'b0;
      tick(); check("hold1_pc", pc, 32'h300C); check("hold1_pend", {31'b0, pend}, 32'h1);
      tick(); check("hold2_pc", pc, 32'h300C);
      stall = 1'b0;
      tick(); check("release_pc", pc, 32'h3100); check("release_pend", {31'b0, pend}, 32'h0);
      tick(); check("after_rel", pc, 32'h3104);

      // newer eret overwrites pending branch
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
      tick(); check("ow_pend", {31'b0, pend}, 32'h1);
      br_valid = 1'b0; eret_req = 1'b1; epc_in = 32'h3200;
      tick(); check("ow_hold_pc", pc, 32'h3104);
      eret_req = 1'b0; stall = 1'b0;
      tick(); check("ow_pc", pc, 32'h3200);

      // misaligned branch ignores stall
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3102;
      tick();
      check("mis_pc", pc, 32'h4180);
      check("mis_bad", badaddr, 32'h3102);
      check("mis_pulse", {31'b0, misalign}, 32'h1);
      check("mis_pend", {31'b0, pend}, 32'h0);
      br_valid = 1'b0;
      tick();
      check("mis_drop", {31'b0, misalign}, 32'h0);
      check("mis_stall_pc", pc, 32'h4180);
      check("bad_keep", badaddr, 32'h3102);
      stall = 1'b0;
      tick(); check("exc_seq", pc, 32'h4184);

      // exception beats branch during HOLD
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
      tick(); check("hold_pend", {31'b0, pend}, 32'h1);
      exc_req = 1'b1; br_target = 32'h3300;
      tick(); check("exc_pc", pc, 32'h4180); check("exc_pend", {31'b0, pend}, 32'h0);
      exc_req = 1'b0; br_valid = 1'b0; stall = 1'b0;
      tick(); check("exc_discard", pc, 32'h4184);

      // eret has priority over branch; misaligned eret target
      eret_req = 1'b1; epc_in = 32'h5000; br_valid = 1'b1; br_target = 32'h6000;
      tick(); check("eret_prio", pc, 32'h5000);
      epc_in = 32'h5001;
      tick(); check("eret_mis_pc", pc, 32'h4180); check("eret_mis_bad", badaddr, 32'h5001);
      eret_req = 1'b0; br_valid = 1'b0;
      tick(); check("eret_mis_next", pc, 32'h4184);

      // 8-bit wrap and asynchronous reset during HOLD
      @(negedge clk);
      clr8 = 1'b1;
      #1 check("w8_0", {24'b0, pc8}, 32'hF8);
      tick(); check("w8_1", {24'b0, pc8}, 32'hFC); check("w8_seq", {24'b0, pc_seq8}, 32'h00);
      tick(); check("w8_wrap", {24'b0, pc8}, 32'h00);
      stall8 = 1'b1; br_valid8 = 1'b1; br_target8 = 8'h40;
      tick(); check("w8_pend", {31'b0, pend8}, 32'h1);
      br_valid8 = 1'b0;
      #2 clr8 = 1'b0;
      #1 check("w8_rst_pc", {24'b0, pc8}, 32'hF8); check("w8_rst_pend", {31'b0, pend8}, 32'h0);
      #1 clr8 = 1'b1; stall8 = 1'b0;
      tick(); check("w8_resume", {24'b0, pc8}, 32'hFC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
